// File: rtl/rmw_pkg.sv
// Shared types for the pipelined read-modify-write unit.
//   OP_W    : width of the operation code carried on in_op
//   op_e    : operation encoding (INC, DEC, ADD immediate, LOAD immediate)
//   state_e : control FSM states (IDLE accepting, DRAIN pipeline, CLEAR sweep)
package rmw_pkg;

   localparam int unsigned OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_INC  = 2'b00,
      OP_DEC  = 2'b01,
      OP_ADD  = 2'b10,
      OP_LOAD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

endpackage

// File: rtl/rmw_if.sv
// Request/completion bus of the read-modify-write unit.
//   in_valid/in_ready        : request handshake (accepted when both are 1)
//   in_addr, in_op, in_imm   : request payload
//   out_valid/addr/data      : completed operation report (no backpressure)
// master drives requests, slave is the unit.
interface rmw_if
   import rmw_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_addr;
   logic [OP_W-1:0]   in_op;
   logic [DATA_W-1:0] in_imm;
   logic              out_valid;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_addr, in_op, in_imm,
      input  in_ready, out_valid, out_addr, out_data
   );

   modport slave (
      input  in_valid, in_addr, in_op, in_imm,
      output in_ready, out_valid, out_addr, out_data
   );
endinterface

// File: rtl/rmw_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// A read and write to the same address on one edge returns the old contents.
//   clk          : clock
//   we/waddr/wdata : write port
//   raddr/rdata  : read port, rdata registered one edge after raddr
module rmw_dp_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Non-blocking update gives read-old-data on collision
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/pipelined_rmw_unit.sv
// Four-stage read-modify-write unit over a 2**ADDR_W x DATA_W memory.
// One request per cycle; hazards resolved by forwarding from S3, S4 and the
// last committed write. A clear request drains the pipeline then zeroes the
// memory with a one-entry-per-cycle sweep.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear_req    : single-cycle request to zero the memory (honoured in IDLE)
//   clear_busy   : drain or clear sweep in progress
//   bus          : request/completion interface (slave side)
module pipelined_rmw_unit
   import rmw_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic  clk,
   input  logic  reset_n,
   input  logic  clear_req,
   output logic  clear_busy,
   rmw_if.slave  bus
);
   state_e            state_q, state_d;
   logic              ready_q, ready_d, busy_d;
   logic [ADDR_W-1:0] clr_addr_q;

   logic              s1_valid, s2_valid, s3_valid, s4_valid, lw_valid;
   logic [ADDR_W-1:0] s1_addr, s2_addr, s3_addr, s4_addr, lw_addr;
   op_e               s1_op, s2_op;
   logic [DATA_W-1:0] s1_imm, s2_imm, s3_data, s4_data, lw_data;

   logic              accept;
   logic [DATA_W-1:0] rd_data, operand, result;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;

   assign accept = bus.in_valid & ready_q;

   // Control FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         ready_q    <= 1'b0;
         clear_busy <= 1'b0;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         clear_busy <= busy_d;
         if (state_q == ST_CLEAR) clr_addr_q <= clr_addr_q + ADDR_W'(1);
      end
   end

   // Control FSM: next state and registered-output decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (clear_req) state_d = ST_DRAIN;
         ST_DRAIN: if (!(s1_valid | s2_valid | s3_valid | s4_valid)) state_d = ST_CLEAR;
         ST_CLEAR: if (clr_addr_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   // Operand forwarding in S2: youngest older write to the same address wins
   always_comb begin
      operand = rd_data;
      if (s3_valid && s3_addr == s2_addr)      operand = s3_data;
      else if (s4_valid && s4_addr == s2_addr) operand = s4_data;
      else if (lw_valid && lw_addr == s2_addr) operand = lw_data;

      result = operand;
      case (s2_op)
         OP_INC:  result = operand + DATA_W'(1);
         OP_DEC:  result = operand - DATA_W'(1);
         OP_ADD:  result = operand + s2_imm;
         OP_LOAD: result = s2_imm;
         default: result = operand;
      endcase
   end

   // Pipeline stages and last-committed-write register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0; s1_addr <= '0; s1_op <= OP_INC; s1_imm <= '0;
         s2_valid <= 1'b0; s2_addr <= '0; s2_op <= OP_INC; s2_imm <= '0;
         s3_valid <= 1'b0; s3_addr <= '0; s3_data <= '0;
         s4_valid <= 1'b0; s4_addr <= '0; s4_data <= '0;
         lw_valid <= 1'b0; lw_addr <= '0; lw_data <= '0;
      end else begin
         s1_valid <= accept;
         s1_addr  <= bus.in_addr;
         s1_op    <= op_e'(bus.in_op);
         s1_imm   <= bus.in_imm;
         s2_valid <= s1_valid;
         s2_addr  <= s1_addr;
         s2_op    <= s1_op;
         s2_imm   <= s1_imm;
         s3_valid <= s2_valid;
         s3_addr  <= s2_addr;
         s3_data  <= result;
         s4_valid <= s3_valid;
         s4_addr  <= s3_addr;
         s4_data  <= s3_data;
         // Covers the read that collided with this edge's write (RAM returns old data)
         lw_valid <= s4_valid & (state_q != ST_CLEAR);
         lw_addr  <= s4_addr;
         lw_data  <= s4_data;
      end
   end

   // Write port: sweep zeroes during CLEAR, otherwise S4 commits
   always_comb begin
      ram_we    = s4_valid;
      ram_waddr = s4_addr;
      ram_wdata = s4_data;
      if (state_q == ST_CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_addr_q;
         ram_wdata = '0;
      end
   end

   rmw_dp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (s1_addr),
      .rdata (rd_data)
   );

   assign bus.in_ready  = ready_q;
   assign bus.out_valid = s4_valid;
   assign bus.out_addr  = s4_addr;
   assign bus.out_data  = s4_data;
endmodule

// File: tb/tb_pipelined_rmw_unit.sv
// Directed bench for pipelined_rmw_unit: hand-computed completions are queued
// with their expected cycle and matched by a negedge monitor.
module tb_pipelined_rmw_unit;
   import rmw_pkg::*;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 4;

   logic clk = 1'b0;
   logic reset_n;
   logic clear_req;
   logic clear_busy;

   rmw_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   pipelined_rmw_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                cyc;
   } exp_t;

   exp_t expq[$];
   exp_t cur;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Completion monitor
   always @(negedge clk) begin
      if (bus.out_valid !== 1'b0) begin
         if (expq.size() == 0) begin
            check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
         end else begin
            cur = expq.pop_front();
            check("out_addr", 32'(bus.out_addr), 32'(cur.addr));
            check("out_data", 32'(bus.out_data), 32'(cur.data));
            check("out_latency", 32'(cyc), 32'(cur.cyc));
         end
      end
   end

   // Present one request for the coming edge; completion expected 3 edges after acceptance
   task automatic send(input logic [ADDR_W-1:0] a, input op_e op, input logic [DATA_W-1:0] imm,
                       input logic [DATA_W-1:0] expd, input bit track);
      @(negedge clk);
      check("in_ready_send", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_addr  = a;
      bus.in_op    = op;
      bus.in_imm   = imm;
      if (track) expq.push_back('{addr: a, data: expd, cyc: cyc + 4});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
   endtask

   // Call at the negedge where clear_req was raised; probes that requests are refused while busy
   task automatic wait_clear(input int exp_busy);
      int n = 0;
      @(negedge clk);
      clear_req = 1'b0;
      check("clear_busy_rise", 32'(clear_busy), 32'd1);
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_addr  = 4'hA;
      bus.in_op    = OP_LOAD;
      bus.in_imm   = 8'h5A;
      while (clear_busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("clear_busy_len", 32'(n), 32'(exp_busy));
      check("in_ready_after_clear", 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n      = 1'b0;
      clear_req    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_addr  = '0;
      bus.in_op    = '0;
      bus.in_imm   = '0;

      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_clear_busy", 32'(clear_busy), 32'd0);
      check("rst_out_addr", 32'(bus.out_addr), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      check("ready_before_edge", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      check("ready_after_edge", 32'(bus.in_ready), 32'd1);

      // Initial clear on an empty pipeline: 1 drain cycle + 16 sweep cycles
      clear_req = 1'b1;
      wait_clear(17);

      // Scenario 1: isolated INCs
      send(4'd3, OP_INC, 8'h00, 8'h01, 1'b1);
      idle(6);
      send(4'd3, OP_INC, 8'h00, 8'h02, 1'b1);
      idle(6);

      // Scenario 2: back-to-back INCs, then gaps exercising S4, last-write and memory paths
      send(4'd5, OP_INC, 8'h00, 8'h01, 1'b1);
      send(4'd5, OP_INC, 8'h00, 8'h02, 1'b1);
      send(4'd5, OP_INC, 8'h00, 8'h03, 1'b1);
      send(4'd5, OP_INC, 8'h00, 8'h04, 1'b1);
      idle(1);
      send(4'd5, OP_INC, 8'h00, 8'h05, 1'b1);
      idle(2);
      send(4'd5, OP_INC, 8'h00, 8'h06, 1'b1);
      idle(3);
      send(4'd5, OP_INC, 8'h00, 8'h07, 1'b1);
      idle(6);

      // Scenario 3: LOAD all-ones, INC wraps to 0, DEC wraps to all-ones
      send(4'd2, OP_LOAD, 8'hFF, 8'hFF, 1'b1);
      send(4'd2, OP_INC, 8'h00, 8'h00, 1'b1);
      send(4'd2, OP_DEC, 8'h00, 8'hFF, 1'b1);
      idle(6);

      // Scenario 5: clear raised alongside the third in-flight op (5 drain + 16 sweep)
      send(4'd5, OP_INC, 8'h00, 8'h08, 1'b1);
      send(4'd5, OP_INC, 8'h00, 8'h09, 1'b1);
      send(4'd5, OP_INC, 8'h00, 8'h0A, 1'b1);
      clear_req = 1'b1;
      wait_clear(21);
      send(4'd12, OP_INC, 8'h00, 8'h01, 1'b1);
      send(4'd5, OP_INC, 8'h00, 8'h01, 1'b1);
      idle(6);

      // Scenario 4: interleaved ADDs, then ADD wrap and DEC of zero
      send(4'd1, OP_ADD, 8'h10, 8'h10, 1'b1);
      send(4'd7, OP_ADD, 8'h10, 8'h10, 1'b1);
      send(4'd1, OP_ADD, 8'h10, 8'h20, 1'b1);
      send(4'd7, OP_ADD, 8'h10, 8'h20, 1'b1);
      idle(1);
      send(4'd1, OP_ADD, 8'hF0, 8'h10, 1'b1);
      send(4'd0, OP_DEC, 8'h00, 8'hFF, 1'b1);
      idle(6);

      // Scenario 6: reset pulse with S1..S4 all occupied discards everything
      send(4'd9, OP_INC, 8'h00, 8'h00, 1'b0);
      send(4'd9, OP_INC, 8'h00, 8'h00, 1'b0);
      send(4'd9, OP_INC, 8'h00, 8'h00, 1'b0);
      send(4'd9, OP_INC, 8'h00, 8'h00, 1'b0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      reset_n      = 1'b0;
      @(negedge clk);
      check("rst2_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst2_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst2_clear_busy", 32'(clear_busy), 32'd0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst2_ready_before_edge", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      check("rst2_ready_after_edge", 32'(bus.in_ready), 32'd1);
      idle(6);
      // Entry 9 must still hold the swept zero if no discarded write landed
      send(4'd9, OP_INC, 8'h00, 8'h01, 1'b1);
      idle(8);

      check("pending_completions", 32'(expq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pipelined_rmw_unit.md
PIPELINED_RMW_UNIT -- requirements
Module: pipelined_rmw_unit

Interface
REQ-001 Parameter DATA_W, default 8, memory word width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth = 2**ADDR_W entries.
REQ-003 Port clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  request present.
REQ-006 Port in_ready  output  1  unit can accept a request this cycle.
REQ-007 Port in_addr  input  ADDR_W  target entry.
REQ-008 Port in_op  input  2  operation: 00 INC, 01 DEC, 10 ADD (add in_imm), 11 LOAD (load in_imm).
REQ-009 Port in_imm  input  DATA_W  immediate operand for ADD and LOAD.
REQ-010 Port clear_req  input  1  single-cycle request to zero the whole memory.
REQ-011 Port clear_busy  output  1  drain or clear sweep in progress.
REQ-012 Port out_valid  output  1  completed operation reported this cycle.
REQ-013 Port out_addr  output  ADDR_W  entry written by the completed operation.
REQ-014 Port out_data  output  DATA_W  new value written to that entry.

Function
REQ-015 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-016 The unit SHALL use four stages: S1 (address register, memory read launched), S2 (read data returned, operand selected), S3 (result computed and registered), S4 (result presented; write committed).
REQ-017 For a request accepted at edge N, out_valid/out_addr/out_data SHALL be valid for the cycle after edge N+3, and the memory write SHALL commit at edge N+4.
REQ-018 Throughput SHALL be one request per cycle, with no stalls for address conflicts.
REQ-019 In S2, the operand SHALL come from the youngest older in-flight write to the same address: S3 result, then S4 result, then the last-committed-write register, then memory read data.
REQ-020 The last-committed-write register SHALL hold the address and data of the write committed at the previous edge, and SHALL be valid for one cycle, to cover read-during-write (the memory returns old data).
REQ-021 Arithmetic SHALL be modulo 2**DATA_W: INC of all-ones gives 0, DEC of 0 gives all-ones, and ADD wraps silently.
REQ-022 The control FSM SHALL have states IDLE, DRAIN and CLEAR; in_ready SHALL be 1 only in IDLE.
REQ-023 IDLE->DRAIN SHALL occur when clear_req=1 in IDLE; a request accepted in that same cycle still completes normally.
REQ-024 DRAIN->CLEAR SHALL occur when the S1..S4 valids are all 0.
REQ-025 CLEAR SHALL write 0 to addresses 0 to 2**ADDR_W-1 in ascending order, one per cycle, through the write port, and SHALL invalidate the last-write register.
REQ-026 CLEAR->IDLE SHALL occur after the write to the final address; the address counter wraps to 0.
REQ-027 clear_req SHALL be ignored outside IDLE.
REQ-028 clear_busy SHALL be 1 exactly when the state is DRAIN or CLEAR.
REQ-029 out_valid SHALL stay 0 during CLEAR sweep writes.

Reset
REQ-030 While reset_n=0, all stage valids, the last-write valid, out_valid and clear_busy SHALL be 0, the state SHALL be IDLE, and all data/address registers SHALL be 0.
REQ-031 in_ready SHALL be 0 while reset_n=0 and SHALL be 1 from the first edge after release.
REQ-032 Memory contents SHALL be undefined after reset; software issues clear_req before use.
REQ-033 Reset during operation SHALL discard all in-flight requests with no further memory writes.

Structure
REQ-034 Package rmw_pkg SHALL hold the op encoding enum (OP_INC, OP_DEC, OP_ADD, OP_LOAD) and the FSM state enum.
REQ-035 Sub-module rmw_dp_ram SHALL be a parametrised dual-port RAM with one synchronous read port, one synchronous write port, and read-old-data behaviour on same-address collision.

Verification
REQ-036 Scenario 1: after clear, INC addr 3 accepted at edge N -> out_valid at N+3 with out_addr=3, out_data=0x01; a later INC addr 3 gives 0x02.
REQ-037 Scenario 2: four back-to-back INC to addr 5 after clear -> out_data 0x01, 0x02, 0x03, 0x04 on consecutive cycles (S3, S4 and last-write forwarding).
REQ-038 Scenario 3: LOAD 0xFF addr 2, then INC addr 2 -> 0x00, then DEC addr 2 -> 0xFF.
REQ-039 Scenario 4: interleaved ADD imm=0x10 to addr 1, 7, 1, 7 after clear -> out_data 0x10, 0x10, 0x20, 0x20.
REQ-040 Scenario 5: clear_req with three ops in flight -> in_ready=0, the three ops complete, 16 sweep cycles, clear_busy=0, then INC to any addr returns 0x01.
REQ-041 Scenario 6: reset_n low for one cycle with S1..S4 valid -> out_valid=0 thereafter, no write observed, in_ready=1 one edge after release.
